// File: rtl/d_flip_flop.sv
// Reference D-flop block: one data input feeding a plain flop, a synchronous-reset
// flop and an asynchronous-clear flop, all clocked on the rising edge of clk.
module d_flip_flop #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_norst_o,
  output logic [WIDTH-1:0] q_syncrst_o,
  output logic [WIDTH-1:0] q_asyncrst_o
);

  logic [WIDTH-1:0] r_q_norst;
  logic [WIDTH-1:0] r_q_syncrst;
  logic [WIDTH-1:0] r_q_asyncrst;

  // No initial value on purpose: this flop stays X until the first edge.
  always_ff @(posedge clk) begin
    r_q_norst <= d_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_syncrst <= RST_VAL;
    end else begin
      r_q_syncrst <= d_i;
    end
  end

  // Clears as soon as reset rises; release only takes effect at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_asyncrst <= RST_VAL;
    end else begin
      r_q_asyncrst <= d_i;
    end
  end

  assign q_norst_o    = r_q_norst;
  assign q_syncrst_o  = r_q_syncrst;
  assign q_asyncrst_o = r_q_asyncrst;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: power-up, data tracking, sync/async reset
// timing, reset isolation and reset coinciding with data.
module tb_d_flip_flop;

  logic clk;
  logic reset;
  logic d_i;
  logic q_norst_o;
  logic q_syncrst_o;
  logic q_asyncrst_o;

  int checks = 0;
  int errors = 0;

  d_flip_flop #(.WIDTH(1), .RST_VAL(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_i          (d_i),
    .q_norst_o    (q_norst_o),
    .q_syncrst_o  (q_syncrst_o),
    .q_asyncrst_o (q_asyncrst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic d, input logic r);
    @(negedge clk);
    d_i   = d;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic en, input logic es, input logic ea);
    chk({tag, ".norst"}, q_norst_o, en);
    chk({tag, ".sync"},  q_syncrst_o, es);
    chk({tag, ".async"}, q_asyncrst_o, ea);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] pat;
    reset = 1'b0;
    d_i   = 1'b0;

    // Power-up: first edge with d_i=0, reset=0
    @(posedge clk);
    #1;
    chk_all("powerup", 1'b0, 1'b0, 1'b0);

    // Data tracking 1,0,1,0,1,0
    pat = 6'b010101;
    for (int i = 0; i < 6; i++) begin
      step(pat[i], 1'b0);
      chk_all($sformatf("track%0d", i), pat[i], pat[i], pat[i]);
    end

    // Synchronous reset: visible only at the edge
    step(1'b1, 1'b0);
    chk("sync_pre", q_syncrst_o, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("sync_before_edge", q_syncrst_o, 1'b1);
    chk("async_immediate", q_asyncrst_o, 1'b0);
    @(posedge clk);
    #1;
    chk_all("sync_at_edge", 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_all("sync_release", 1'b1, 1'b1, 1'b1);

    // Async reset asserted 2.5 ns after a rising edge
    @(posedge clk);
    #2.5;
    reset = 1'b1;
    #1;
    chk("async_clear", q_asyncrst_o, 1'b0);
    chk("async_sync_hold", q_syncrst_o, 1'b1);
    chk("async_norst_hold", q_norst_o, 1'b1);
    @(posedge clk);
    #1;
    chk_all("async_next_edge", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_release_no_capture", q_asyncrst_o, 1'b0);
    @(posedge clk);
    #1;
    chk_all("async_recapture", 1'b1, 1'b1, 1'b1);

    // Reset pulse entirely between edges: sync flop unaffected
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("pulse_async_clear", q_asyncrst_o, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("pulse_between_edges", 1'b1, 1'b1, 1'b1);

    // Reset isolation
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk_all("iso_reset", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_all("iso_release", 1'b1, 1'b1, 1'b1);

    // Reset coinciding with d_i=1
    step(1'b1, 1'b1);
    chk_all("simul", 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_all("after_simul", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
